// File: rtl/crc_pkg.sv
// Shared CRC helpers: serial-equivalent parallel LFSR update, reflections, engine states.
package crc_pkg;

  localparam int unsigned CRC_MAX  = 32;
  localparam int unsigned DATA_MAX = 128;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  function automatic logic [7:0] refl8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

  function automatic logic [CRC_MAX-1:0] bitrev(input logic [CRC_MAX-1:0] v,
                                                input int unsigned       w);
    logic [CRC_MAX-1:0] r;
    r = '0;
    for (int i = 0; i < CRC_MAX; i++) begin
      if (i < w) r[i] = v[w-1-i];
    end
    return r;
  endfunction

  // One beat folded in as data_w consecutive serial steps; width-limited by mask.
  function automatic logic [CRC_MAX-1:0] crc_next(input logic [CRC_MAX-1:0]  lfsr,
                                                  input logic [DATA_MAX-1:0] data,
                                                  input int unsigned         data_w,
                                                  input logic [CRC_MAX-1:0]  poly,
                                                  input int unsigned         crc_w,
                                                  input logic                refin);
    logic [CRC_MAX-1:0] r;
    logic [CRC_MAX-1:0] mask;
    logic [7:0]         byt;
    logic               b;
    logic               fb;
    mask = '0;
    for (int i = 0; i < CRC_MAX; i++) begin
      if (i < crc_w) mask[i] = 1'b1;
    end
    r = lfsr & mask;
    for (int i = 0; i < DATA_MAX; i++) begin
      if (i < data_w) begin
        if (refin) begin
          // Byte 0 first; reflecting the byte turns LSB-first into an MSB-first walk.
          byt = refl8(data[(i/8)*8 +: 8]);
          b   = byt[7-(i%8)];
        end else begin
          b = data[data_w-1-i];
        end
        fb = r[crc_w-1] ^ b;
        r  = ((r << 1) ^ (fb ? poly : '0)) & mask;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/crc_parallel_step.sv
// Combinational next-LFSR over one DATA_W-bit beat for any CRC_W/POLY.
// Zero latency; no handshake, pure function of its inputs.
module crc_parallel_step
  import crc_pkg::*;
#(
  parameter int              CRC_W  = 16,
  parameter logic [CRC_W-1:0] POLY  = 16'h8005,
  parameter int              DATA_W = 16,
  parameter bit              REFIN  = 1'b0
) (
  input  logic [CRC_W-1:0]  lfsr_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [CRC_W-1:0]  lfsr_o
);

  logic [CRC_MAX-1:0]  lfsr_ext;
  logic [CRC_MAX-1:0]  poly_ext;
  logic [CRC_MAX-1:0]  next_ext;
  logic [DATA_MAX-1:0] data_ext;
  logic                unused_hi;

  always_comb begin
    lfsr_ext              = '0;
    lfsr_ext[CRC_W-1:0]   = lfsr_i;
    poly_ext              = '0;
    poly_ext[CRC_W-1:0]   = POLY;
    data_ext              = '0;
    data_ext[DATA_W-1:0]  = data_i;
    next_ext = crc_next(lfsr_ext, data_ext, DATA_W, poly_ext, CRC_W, REFIN);
    lfsr_o   = next_ext[CRC_W-1:0];
  end

  assign unused_hi = ^next_ext;

endmodule

// File: rtl/crc_stream_engine.sv
// Frame-aware CRC engine: one beat per cycle, finalised result held until taken.
// Result valid the cycle after the eof beat; in_ready drops while a result is held.
module crc_stream_engine
  import crc_pkg::*;
#(
  parameter int               CRC_W   = 16,
  parameter logic [CRC_W-1:0] POLY    = 16'h8005,
  parameter logic [CRC_W-1:0] INIT    = '0,
  parameter logic [CRC_W-1:0] XOROUT  = '0,
  parameter bit               REFIN   = 1'b0,
  parameter bit               REFOUT  = 1'b0,
  parameter int               DATA_W  = 16,
  parameter logic [CRC_W-1:0] RESIDUE = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_sof,
  input  logic              in_eof,
  output logic              crc_valid,
  input  logic              crc_ready,
  output logic [CRC_W-1:0]  crc_out,
  output logic              crc_match
);

  state_t             state_q, state_d;
  logic [CRC_W-1:0]   lfsr_q, lfsr_d;
  logic [CRC_W-1:0]   crc_q, crc_d;
  logic               match_q, match_d;
  logic [CRC_W-1:0]   start_val;
  logic [CRC_W-1:0]   step_val;
  logic [CRC_W-1:0]   result;
  logic [CRC_MAX-1:0] step_ext;
  logic [CRC_MAX-1:0] rev_ext;
  logic               accept;
  logic               unused_rev;

  // Outputs depend only on registered state, so crc_ready never reaches in_ready.
  assign in_ready  = (state_q != HOLD);
  assign crc_valid = (state_q == HOLD);
  assign crc_out   = crc_q;
  assign crc_match = match_q & crc_valid;
  assign accept    = in_valid & in_ready;

  always_comb begin
    start_val = lfsr_q;
    if (in_sof || (state_q == IDLE)) start_val = INIT;
  end

  crc_parallel_step #(
    .CRC_W  (CRC_W),
    .POLY   (POLY),
    .DATA_W (DATA_W),
    .REFIN  (REFIN)
  ) u_step (
    .lfsr_i (start_val),
    .data_i (in_data),
    .lfsr_o (step_val)
  );

  always_comb begin
    step_ext            = '0;
    step_ext[CRC_W-1:0] = step_val;
    rev_ext             = bitrev(step_ext, CRC_W);
    result              = (REFOUT ? rev_ext[CRC_W-1:0] : step_val) ^ XOROUT;
  end

  assign unused_rev = ^rev_ext;

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    crc_d   = crc_q;
    match_d = match_q;
    case (state_q)
      IDLE, RUN: begin
        if (accept) begin
          if (in_eof) begin
            crc_d   = result;
            match_d = (result == RESIDUE);
            lfsr_d  = INIT;
            state_d = HOLD;
          end else begin
            lfsr_d  = step_val;
            state_d = RUN;
          end
        end
      end
      HOLD: begin
        if (crc_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      lfsr_q  <= INIT;
      crc_q   <= '0;
      match_q <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      crc_q   <= crc_d;
      match_q <= match_d;
    end
  end

endmodule

// File: tb/tb_crc_stream_engine.sv
// Directed checks of several CRC configurations sharing one byte stream, plus a 32-bit-beat instance.
module tb_crc_stream_engine;

  logic clk;
  logic reset;
  logic in_valid, in_sof, in_eof, crc_ready;
  logic [7:0] in_data;

  logic        bp_rdy, bp_vld, bp_match;
  logic [15:0] bp_out;
  logic        arc_rdy, arc_vld, arc_match;
  logic [15:0] arc_out;
  logic        cc_rdy, cc_vld, cc_match;
  logic [15:0] cc_out;
  logic        c32_rdy, c32_vld, c32_match;
  logic [31:0] c32_out;

  logic        w_valid, w_sof, w_eof, w_cready;
  logic [31:0] w_data;
  logic        w_rdy, w_vld, w_match;
  logic [31:0] w_out;

  int tests = 0;
  int fails = 0;
  byte unsigned frm[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  crc_stream_engine #(.CRC_W(16), .POLY(16'h8005), .INIT(16'h0000), .XOROUT(16'h0000),
    .REFIN(1'b0), .REFOUT(1'b0), .DATA_W(8), .RESIDUE(16'h0000)) u_bp (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(bp_rdy), .in_data(in_data),
    .in_sof(in_sof), .in_eof(in_eof), .crc_valid(bp_vld), .crc_ready(crc_ready),
    .crc_out(bp_out), .crc_match(bp_match));

  crc_stream_engine #(.CRC_W(16), .POLY(16'h8005), .INIT(16'h0000), .XOROUT(16'h0000),
    .REFIN(1'b1), .REFOUT(1'b1), .DATA_W(8), .RESIDUE(16'h0000)) u_arc (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(arc_rdy), .in_data(in_data),
    .in_sof(in_sof), .in_eof(in_eof), .crc_valid(arc_vld), .crc_ready(crc_ready),
    .crc_out(arc_out), .crc_match(arc_match));

  crc_stream_engine #(.CRC_W(16), .POLY(16'h1021), .INIT(16'hFFFF), .XOROUT(16'h0000),
    .REFIN(1'b0), .REFOUT(1'b0), .DATA_W(8), .RESIDUE(16'h0000)) u_cc (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(cc_rdy), .in_data(in_data),
    .in_sof(in_sof), .in_eof(in_eof), .crc_valid(cc_vld), .crc_ready(crc_ready),
    .crc_out(cc_out), .crc_match(cc_match));

  crc_stream_engine #(.CRC_W(32), .POLY(32'h04C11DB7), .INIT(32'hFFFFFFFF),
    .XOROUT(32'hFFFFFFFF), .REFIN(1'b1), .REFOUT(1'b1), .DATA_W(8),
    .RESIDUE(32'h2144DF1C)) u_c32 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(c32_rdy), .in_data(in_data),
    .in_sof(in_sof), .in_eof(in_eof), .crc_valid(c32_vld), .crc_ready(crc_ready),
    .crc_out(c32_out), .crc_match(c32_match));

  crc_stream_engine #(.CRC_W(32), .POLY(32'h04C11DB7), .INIT(32'hFFFFFFFF),
    .XOROUT(32'hFFFFFFFF), .REFIN(1'b1), .REFOUT(1'b1), .DATA_W(32),
    .RESIDUE(32'h2144DF1C)) u_w32 (
    .clk(clk), .reset(reset), .in_valid(w_valid), .in_ready(w_rdy), .in_data(w_data),
    .in_sof(w_sof), .in_eof(w_eof), .crc_valid(w_vld), .crc_ready(w_cready),
    .crc_out(w_out), .crc_match(w_match));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic load_str(input string s);
    frm.delete();
    for (int i = 0; i < s.len(); i++) frm.push_back(s[i]);
  endtask

  // Reflected table-free CRC-32 reference, independent of the DUT's MSB-first form.
  function automatic logic [31:0] crc32_ref();
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (frm[i]) begin
      c = c ^ {24'h0, frm[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic send_frm(input bit sof_first, input bit eof_last);
    for (int i = 0; i < frm.size(); i++) begin
      in_valid = 1'b1;
      in_data  = frm[i];
      in_sof   = sof_first && (i == 0);
      in_eof   = eof_last && (i == frm.size() - 1);
      if (i == frm.size() - 1) chk("valid_before_last", {31'h0, bp_vld}, 32'h0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_sof   = 1'b0;
    in_eof   = 1'b0;
  endtask

  task automatic send_w();
    for (int k = 0; k < frm.size() / 4; k++) begin
      w_valid = 1'b1;
      w_data  = {frm[4*k+3], frm[4*k+2], frm[4*k+1], frm[4*k]};
      w_sof   = (k == 0);
      w_eof   = (k == frm.size() / 4 - 1);
      @(posedge clk); #1;
    end
    w_valid = 1'b0;
    w_sof   = 1'b0;
    w_eof   = 1'b0;
  endtask

  task automatic release_n();
    crc_ready = 1'b1;
    @(posedge clk); #1;
    crc_ready = 1'b0;
    chk("valid_after_take", {31'h0, bp_vld}, 32'h0);
    chk("ready_after_take", {31'h0, bp_rdy}, 32'h1);
  endtask

  task automatic release_w();
    w_cready = 1'b1;
    @(posedge clk); #1;
    w_cready = 1'b0;
    chk("w_valid_after_take", {31'h0, w_vld}, 32'h0);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_eof = 1'b0; in_data = 8'h00;
    crc_ready = 1'b0; w_valid = 1'b0; w_sof = 1'b0; w_eof = 1'b0; w_data = 32'h0;
    w_cready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", {31'h0, bp_rdy}, 32'h1);
    chk("rst_crc_valid", {31'h0, bp_vld}, 32'h0);
    chk("rst_crc_out", {16'h0, bp_out}, 32'h0);
    chk("rst_crc_match", {31'h0, c32_match}, 32'h0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Check string through all four byte-wide configurations.
    load_str("123456789");
    send_frm(1'b1, 1'b1);
    chk("latency_valid", {31'h0, bp_vld}, 32'h1);
    chk("buypass", {16'h0, bp_out}, 32'h0000FEE8);
    chk("arc", {16'h0, arc_out}, 32'h0000BB3D);
    chk("ccitt_false", {16'h0, cc_out}, 32'h000029B1);
    chk("crc32", c32_out, 32'hCBF43926);
    chk("crc32_match0", {31'h0, c32_match}, 32'h0);
    chk("hold_in_ready", {31'h0, c32_rdy}, 32'h0);
    release_n();

    // Frame carrying its own CRC lands on the residue.
    load_str("123456789");
    frm.push_back(8'h26); frm.push_back(8'h39); frm.push_back(8'hF4); frm.push_back(8'hCB);
    send_frm(1'b1, 1'b1);
    chk("residue_out", c32_out, 32'h2144DF1C);
    chk("residue_match", {31'h0, c32_match}, 32'h1);
    release_n();

    // Backpressure: result held, offered beats ignored.
    load_str("123456789");
    send_frm(1'b1, 1'b1);
    in_valid = 1'b1; in_data = 8'hAA; in_sof = 1'b1; in_eof = 1'b1;
    for (int c = 0; c < 5; c++) begin
      chk("bp_valid_held", {31'h0, bp_vld}, 32'h1);
      chk("bp_out_held", {16'h0, bp_out}, 32'h0000FEE8);
      chk("bp_ready_low", {31'h0, bp_rdy}, 32'h0);
      @(posedge clk); #1;
    end
    crc_ready = 1'b1;
    @(posedge clk); #1;
    crc_ready = 1'b0;
    chk("bp_ready_after_release", {31'h0, bp_rdy}, 32'h1);
    chk("bp_out_after_release", c32_out, 32'hCBF43926);
    in_valid = 1'b0; in_sof = 1'b0; in_eof = 1'b0;
    @(posedge clk); #1;

    // Single-beat frame.
    load_str("a");
    send_frm(1'b1, 1'b1);
    chk("single_buypass", {16'h0, bp_out}, 32'h00008145);
    chk("single_crc32", c32_out, 32'hE8B7BE43);
    release_n();

    // sof mid-frame restarts the computation.
    load_str("XY");
    send_frm(1'b1, 1'b0);
    load_str("123456789");
    send_frm(1'b1, 1'b1);
    chk("restart_buypass", {16'h0, bp_out}, 32'h0000FEE8);
    chk("restart_arc", {16'h0, arc_out}, 32'h0000BB3D);
    chk("restart_ccitt", {16'h0, cc_out}, 32'h000029B1);
    chk("restart_crc32", c32_out, 32'hCBF43926);
    release_n();

    // Reset mid-frame, then a frame with implicit start from IDLE.
    load_str("12");
    send_frm(1'b1, 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rst_run_valid", {31'h0, bp_vld}, 32'h0);
    chk("rst_run_ready", {31'h0, bp_rdy}, 32'h1);
    load_str("123456789");
    send_frm(1'b0, 1'b1);
    chk("post_rst_buypass", {16'h0, bp_out}, 32'h0000FEE8);
    chk("post_rst_crc32", c32_out, 32'hCBF43926);
    release_n();

    // Random 64-byte frames: 32-bit and 8-bit beats against the reference.
    for (int f = 0; f < 3; f++) begin
      logic [31:0] exp;
      frm.delete();
      for (int i = 0; i < 64; i++) frm.push_back(8'($urandom_range(0, 255)));
      exp = crc32_ref();
      send_w();
      chk("wide_crc32", w_out, exp);
      release_w();
      send_frm(1'b1, 1'b1);
      chk("narrow_crc32", c32_out, exp);
      release_n();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
